// File: rtl/sdf_combine_n_if.sv
// sdf_combine_n_if: primitive distances, operator config and combined
// scene-distance output of the N-input SDF combiner.
interface sdf_combine_n_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DW         = 27
);
    logic                     i_valid;
    logic [NUM_INPUTS*DW-1:0] i_dist;
    logic                     cfg_we;
    logic [2:0]               cfg_idx;
    logic [1:0]               cfg_op;
    logic                     cfg_commit;
    logic                     o_valid;
    logic [DW-1:0]            o_dist;
    logic                     o_idle;
    logic [2*NUM_INPUTS-1:0]  o_active_ops;

    modport master (
        output i_valid, i_dist, cfg_we, cfg_idx, cfg_op, cfg_commit,
        input  o_valid, o_dist, o_idle, o_active_ops
    );

    modport slave (
        input  i_valid, i_dist, cfg_we, cfg_idx, cfg_op, cfg_commit,
        output o_valid, o_dist, o_idle, o_active_ops
    );
endinterface

// File: rtl/sdf_combine_n.sv
// sdf_combine_n: delay-aligns N primitive distances and folds them
// left-to-right through a registered union/intersect/difference chain.
module sdf_combine_n #(
    parameter int                      NUM_INPUTS = 4,
    parameter int                      DW         = 27,
    parameter logic [8*NUM_INPUTS-1:0] LAT_VEC    = {8'd11, 8'd9, 8'd11, 8'd9}
) (
    input  logic           clk,
    input  logic           rst_n,
    sdf_combine_n_if.slave bus
);
    function automatic int max_lat_f(input logic [8*NUM_INPUTS-1:0] v);
        int m;
        m = 0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (int'(v[8*k +: 8]) > m) m = int'(v[8*k +: 8]);
        return m;
    endfunction

    localparam int MAX_LAT = max_lat_f(LAT_VEC);
    localparam int NS      = NUM_INPUTS - 1;
    localparam int OPW     = 2 * NS;

    // Slice k must reach chain stage k in the same cycle as its sample.
    function automatic int dly_f(input int k);
        int d;
        d = MAX_LAT - int'(LAT_VEC[8*k +: 8]);
        if (k >= 1) d = d + k - 1;
        return d;
    endfunction

    // Sign-magnitude less-than; +0 and -0 compare equal.
    function automatic logic f_lt(input logic [DW-1:0] a,
                                  input logic [DW-1:0] b);
        if (a[DW-2:0] == '0 && b[DW-2:0] == '0) return 1'b0;
        if (a[DW-1] != b[DW-1]) return a[DW-1];
        if (!a[DW-1]) return a[DW-2:0] < b[DW-2:0];
        return a[DW-2:0] > b[DW-2:0];
    endfunction

    // Ties keep the accumulator.
    function automatic logic [DW-1:0] f_op(input logic [1:0]    op,
                                           input logic [DW-1:0] acc,
                                           input logic [DW-1:0] d);
        logic [DW-1:0] nd;
        logic [DW-1:0] r;
        nd = {~d[DW-1], d[DW-2:0]};
        case (op)
            2'b01:   r = f_lt(d, acc) ? d : acc;
            2'b10:   r = f_lt(acc, d) ? d : acc;
            2'b11:   r = f_lt(acc, nd) ? nd : acc;
            default: r = acc;
        endcase
        return r;
    endfunction

    logic            vld_a;
    logic            line_busy;
    logic [DW-1:0]   d_al   [NUM_INPUTS];
    logic [OPW-1:0]  shd_q, shd_d;
    logic [OPW-1:0]  act_q, act_d;
    logic [DW-1:0]   acc_q  [NS];
    logic [NS-1:0]   vld_q;
    logic [OPW-1:0]  tag_q  [NS];
    logic [DW-1:0]   in_acc [NS];
    logic [NS-1:0]   in_vld;
    logic [OPW-1:0]  in_tag [NS];

    generate
        if (MAX_LAT == 0) begin : g_vnone
            assign vld_a     = bus.i_valid;
            assign line_busy = 1'b0;
        end else begin : g_vline
            logic [MAX_LAT-1:0] line_q;
            // Carry the entry strobe to the aligned cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_q <= '0;
                end else begin
                    line_q[0] <= bus.i_valid;
                    for (int j = 1; j < MAX_LAT; j++)
                        line_q[j] <= line_q[j-1];
                end
            end
            assign vld_a     = line_q[MAX_LAT-1];
            assign line_busy = |line_q;
        end

        for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_dly
            localparam int D = dly_f(k);
            if (D == 0) begin : g_wire
                assign d_al[k] = bus.i_dist[k*DW +: DW];
            end else begin : g_reg
                logic [DW-1:0] q [D];
                // Pad the faster primitives up to their chain stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int j = 0; j < D; j++) q[j] <= '0;
                    end else begin
                        q[0] <= bus.i_dist[k*DW +: DW];
                        for (int j = 1; j < D; j++) q[j] <= q[j-1];
                    end
                end
                assign d_al[k] = q[D-1];
            end
        end
    endgenerate

    // Shadow write (slot 0 and out-of-range ignored); commit sees it.
    always_comb begin
        shd_d = shd_q;
        if (bus.cfg_we && bus.cfg_idx != 3'd0 &&
            int'(bus.cfg_idx) < NUM_INPUTS)
            shd_d[2*(int'(bus.cfg_idx) - 1) +: 2] = bus.cfg_op;
        act_d = bus.cfg_commit ? shd_d : act_q;
    end

    // Shadow and active op registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_q <= {NS{2'b01}};
            act_q <= {NS{2'b01}};
        end else begin
            shd_q <= shd_d;
            act_q <= act_d;
        end
    end

    // Stage 0 is combinational; tags shift so [1:0] is always next op.
    always_comb begin
        in_acc[0] = d_al[0];
        in_vld    = '0;
        in_vld[0] = vld_a;
        in_tag[0] = act_q;
        for (int k = 1; k < NS; k++) begin
            in_acc[k] = acc_q[k-1];
            in_vld[k] = vld_q[k-1];
            in_tag[k] = tag_q[k-1] >> 2;
        end
    end

    // Registered fold stages; distances hold when no sample passes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < NS; k++) begin
                acc_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= in_vld;
            for (int k = 0; k < NS; k++) begin
                tag_q[k] <= in_tag[k];
                if (in_vld[k])
                    acc_q[k] <= f_op(in_tag[k][1:0], in_acc[k], d_al[k+1]);
            end
        end
    end

    assign bus.o_valid      = vld_q[NS-1];
    assign bus.o_dist       = acc_q[NS-1];
    assign bus.o_idle       = ~(line_busy | (|vld_q));
    assign bus.o_active_ops = {act_q, 2'b00};
endmodule

// File: tb/tb_sdf_combine_n.sv
// tb_sdf_combine_n: directed scenarios with a scoreboard of expected
// scene distances and their output cycles.
module tb_sdf_combine_n;
    localparam int             N       = 4;
    localparam int             DW      = 27;
    localparam logic [8*N-1:0] LATV    = {8'd11, 8'd9, 8'd11, 8'd9};
    localparam int             LATENCY = 14;
    localparam int             RING    = 512;

    localparam logic [DW-1:0] P1   = 27'h1fc0000;
    localparam logic [DW-1:0] H    = 27'h1f80000;
    localparam logic [DW-1:0] TWO  = 27'h2000000;
    localparam logic [DW-1:0] NEG1 = 27'h5fc0000;
    localparam logic [DW-1:0] Q    = 27'h1f40000;
    localparam logic [DW-1:0] NH   = 27'h5f80000;
    localparam logic [DW-1:0] NZ   = 27'h4000000;
    localparam logic [DW-1:0] PZ   = 27'h0000000;

    typedef struct packed {
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    int            t0;
    exp_t          sb [$];
    logic [DW-1:0] sched [RING][N];

    sdf_combine_n_if #(.NUM_INPUTS(N), .DW(DW)) bus ();

    sdf_combine_n #(
        .NUM_INPUTS(N),
        .DW        (DW),
        .LAT_VEC   (LATV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Primitive pipelines: each slice shows up at its own latency.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++)
            bus.i_dist[k*DW +: DW] = sched[cyc % RING][k];
    end

    function automatic int lat(input int k);
        logic [8*N-1:0] v;
        v = LATV;
        return int'(v[8*k +: 8]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor pops the scoreboard on every o_valid.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_valid === 1'b1) begin
            exp_t e;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_valid: observed dist %h at cycle %0d expected no output",
                       bus.o_dist, cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (bus.o_dist === e.d) else begin
                    errors++;
                    $error("FAIL o_dist: observed %h expected %h", bus.o_dist, e.d);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL out_cycle: observed %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                         input logic [DW-1:0] e);
        logic [DW-1:0] dv [N];
        exp_t          x;
        dv[0] = d0;
        dv[1] = d1;
        dv[2] = d2;
        dv[3] = d3;
        bus.i_valid = 1'b1;
        for (int k = 0; k < N; k++)
            sched[(cyc + lat(k)) % RING][k] = dv[k];
        x.d   = e;
        x.cyc = cyc + LATENCY;
        sb.push_back(x);
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [1:0] op,
                       input logic commit);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = idx;
        bus.cfg_op     = op;
        bus.cfg_commit = commit;
        step();
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && bus.o_idle === 1'b1) break;
            step();
        end
        chk(tag, sb.size(), 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.o_idle}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < RING; i++)
            for (int k = 0; k < N; k++) sched[i][k] = '0;
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_dist     = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_idx    = 3'd0;
        bus.cfg_op     = 2'b00;
        bus.cfg_commit = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        #2;
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_dist", {5'd0, bus.o_dist}, 32'd0);
        chk("rst_idle", {31'd0, bus.o_idle}, 32'd1);
        chk("rst_ops", {24'd0, bus.o_active_ops}, 32'h54);

        // Default union with latency and idle timing.
        step();
        t0 = cyc;
        issue(P1, H, TWO, P1, H);
        step();
        bus.i_valid = 1'b0;
        while (cyc < t0 + LATENCY) step();
        #2;
        chk("busy_at_out", {31'd0, bus.o_idle}, 32'd0);
        chk("valid_at_out", {31'd0, bus.o_valid}, 32'd1);
        step();
        #2;
        chk("idle_after_out", {31'd0, bus.o_idle}, 32'd1);
        chk("valid_after_out", {31'd0, bus.o_valid}, 32'd0);
        drain("drain_union");

        // Difference on input 1, later inputs disabled.
        cfg(3'd1, 2'b11, 1'b0);
        cfg(3'd2, 2'b00, 1'b0);
        cfg(3'd3, 2'b00, 1'b1);
        chk("ops_diff", {24'd0, bus.o_active_ops}, 32'h0c);
        issue(H, NEG1, NEG1, TWO, P1);
        step();
        issue(H, Q, P1, NEG1, H);
        step();
        bus.i_valid = 1'b0;
        drain("drain_diff");

        // Sign handling.
        cfg(3'd1, 2'b10, 1'b1);
        chk("ops_isect", {24'd0, bus.o_active_ops}, 32'h08);
        issue(NEG1, H, NEG1, NEG1, H);
        step();
        bus.i_valid = 1'b0;
        drain("drain_isect");
        cfg(3'd1, 2'b01, 1'b1);
        chk("ops_union1", {24'd0, bus.o_active_ops}, 32'h04);
        issue(NEG1, NH, TWO, TWO, NEG1);
        step();
        issue(PZ, NZ, NEG1, NEG1, PZ);
        step();
        bus.i_valid = 1'b0;
        drain("drain_sign");

        // Commit lands in sample 3's aligned cycle.
        cfg(3'd1, 2'b10, 1'b0);
        chk("ops_shadow_only", {24'd0, bus.o_active_ops}, 32'h04);
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            issue(P1, H, TWO, TWO, (i < 4) ? H : P1);
            step();
        end
        bus.i_valid = 1'b0;
        while (cyc < t0 + 3 + 11) step();
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        chk("ops_tagged", {24'd0, bus.o_active_ops}, 32'h08);
        drain("drain_tagged");

        // Reset with samples in flight.
        for (int i = 0; i < 5; i++) begin
            issue(P1, H, TWO, TWO, H);
            step();
        end
        bus.i_valid = 1'b0;
        step();
        step();
        sb.delete();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            #2;
            chk("rst_flight_valid", {31'd0, bus.o_valid}, 32'd0);
        end
        chk("rst_flight_dist", {5'd0, bus.o_dist}, 32'd0);
        chk("rst_flight_idle", {31'd0, bus.o_idle}, 32'd1);
        chk("rst_flight_ops", {24'd0, bus.o_active_ops}, 32'h54);

        // Ignored slots, then a write merged into its own commit.
        cfg(3'd0, 2'b10, 1'b0);
        cfg(3'd5, 2'b11, 1'b0);
        cfg(3'd4, 2'b10, 1'b1);
        chk("ops_ignored", {24'd0, bus.o_active_ops}, 32'h54);
        cfg(3'd3, 2'b10, 1'b1);
        chk("ops_same_cycle", {24'd0, bus.o_active_ops}, 32'h94);
        issue(P1, H, TWO, TWO, TWO);
        step();
        bus.i_valid = 1'b0;
        drain("drain_mixed");

        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdf_combine_n.md
Name: sdf_combine_n

Overview:
- Parametrised N-input SDF scene combiner for the raymarcher distance path.
- Takes 27-bit float distances from N primitive pipelines (box, sphere, tetrahedron, inf_cross, ...) with differing latencies and delay-aligns them.
- Folds them left-to-right through a registered chain of union, intersection and difference operators to produce one scene distance with a valid strobe.
- Per-input operators are runtime-configurable through shadow registers. Each sample carries the operator set that was active when it entered the chain, so configuration can change mid-stream without corrupting in-flight samples.

Parameters:
- NUM_INPUTS, 4, number of distance inputs, legal range 2..8.
- DW, 27, distance width: 1 sign, 8 exponent, 18 mantissa float.
- LAT_VEC, {8'd11,8'd9,8'd11,8'd9}, packed 8-bit pipeline latency of each primitive; input 0 is in the LSBs.
- MAX_LAT, derived by a constant function as the maximum LAT_VEC entry; not user-set.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  point entered the primitives this cycle (time t).
- i_dist  in  NUM_INPUTS*DW  slice k is primitive k's distance, valid at t+LAT_k.
- cfg_we  in  1  write cfg_op into the shadow op for cfg_idx.
- cfg_idx  in  3  input index being configured.
- cfg_op  in  2  operator: 00 disabled, 01 union min, 10 intersection max, 11 difference max(acc,-d).
- cfg_commit  in  1  copy shadow ops to active ops.
- o_valid  out  1  o_dist valid.
- o_dist  out  DW  combined scene distance.
- o_idle  out  1  no valid sample in flight.
- o_active_ops  out  2*NUM_INPUTS  active op vector; bits [1:0] (input 0) are always 00.

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values: o_valid=0, o_dist=0, o_idle=1, all valid pipeline bits cleared. Shadow and active ops reset to 01 for inputs 1..N-1.
- Alignment:
  - i_valid is delayed MAX_LAT cycles. The aligned cycle is a = t+MAX_LAT.
  - Slice k is delayed (MAX_LAT-LAT_k)+(k-1) cycles for k>=1 and (MAX_LAT-LAT_0) for k=0.
  - Slice k therefore arrives at chain stage k exactly when the sample does. Zero-length delays are wires.
- Chain:
  - Stage 0 is combinational at cycle a: acc=d0. It captures the active op vector into the sample's tag.
  - Stage k (1..N-1) is a register: acc_k = op_k(acc_{k-1}, d_k), using the sample's tagged op_k. Op 00 passes acc unchanged.
  - o_dist/o_valid are the stage N-1 register.
  - Total latency: LATENCY = MAX_LAT+NUM_INPUTS-1 cycles from i_valid to o_valid.
- Throughput: one sample per cycle, with no stalls and no backpressure.
- o_dist when invalid: holds its last value; it is not cleared.
- Float compare:
  - Sign-magnitude. Negative is less than positive. Two positives compare by magnitude bits [25:0]; two negatives compare reversed.
  - +0 and -0 are equal; ties select acc.
  - Negation flips bit 26. NaN and inf are not handled; they are compared as ordinary bit patterns.
- Config:
  - cfg_we with cfg_idx in 1..N-1 updates the shadow next edge. cfg_idx=0 or cfg_idx>=N is ignored.
  - cfg_commit in cycle c makes active=shadow from cycle c+1.
  - cfg_we and cfg_commit in the same cycle: the commit includes that write.
  - A sample whose aligned cycle is <= c uses the old ops; a sample with aligned cycle > c uses the new ops.
- o_idle=1 iff no valid bit is set in any delay or chain stage.
- Reset mid-operation: all in-flight samples are discarded and no o_valid pulse appears after deassertion. Ops return to union.

Test Plan:
- Default union: N=4, LAT_VEC={11,9,11,9}. i_valid pulse at t=0 with d0=1.0 (0x1fc0000), d1=0.5 (0x1f80000), d2=2.0 (0x2000000), d3=1.0, each at its latency -> single o_valid at cycle 14, o_dist=0x1f80000, o_idle returns to 1 at 15.
- Difference: op1=11, op2/op3=00, commit. d0=0.5, d1=-1.0 (0x5fc0000) -> o_dist=0x1fc0000. Then d0=0.5, d1=0.25 (0x1f40000) -> 0x1f80000.
- Sign handling: op1=10 with d0=-1.0, d1=0.5 -> 0x1f80000. Op1=01 with d0=-1.0, d1=-0.5 (0x5f80000) -> 0x5fc0000. Union of +0 and -0 (0x4000000) -> 0x0000000 (acc).
- Tagged commit: six back-to-back i_valid samples, d0=1.0, d1=0.5. Commit op1=10 in sample 3's aligned cycle -> samples 0-3 output 0x1f80000, samples 4-5 output 0x1fc0000 in consecutive cycles.
- Ignored config: cfg_we with cfg_idx=0 and cfg_idx=5 (N=4), then commit -> o_active_ops unchanged (0x54).
- Reset mid-flight: five samples in flight, rst_n low for one cycle -> o_valid stays 0 for the next 20 cycles, o_dist=0, o_idle=1, o_active_ops=0x54.
